// File: rtl/vga_rx_monitor.sv
// ---------------------------------------------------------------------------
// vga_rx_monitor
//
// Passive monitor for an incoming VGA timing/pixel stream. It measures line
// and frame geometry, detects sync polarity, checksums each frame, and locks
// onto a stable format. While locked it emits a qualified pixel strobe with
// active-area coordinates, two clocks after the pixel is seen at the pins.
//
// Ports
//   clk                              pixel clock, rising edge
//   rst_n                            asynchronous active-low reset
//   hsync, vsync, hblank, vblank     incoming timing (blanks high in blanking)
//   r, g, b                          incoming pixel colour
//   pix_valid                        visible pixel while locked (registered)
//   hpos, vpos                       active-area coordinates of that pixel
//   locked                           FSM is in LOCKED
//   htotal, hactive                  last measured line length / active width
//   vtotal, vactive                  last measured frame lines / active lines
//   hs_pol, vs_pol                   detected active sync level (1 = high)
//   frame_sum                        mod-2^16 sum of (r^g^b) of last frame
//   lost_count                       number of lock losses, saturating
// ---------------------------------------------------------------------------
module vga_rx_monitor #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] b,
  output logic              pix_valid,
  output logic [9:0]        hpos,
  output logic [9:0]        vpos,
  output logic              locked,
  output logic [9:0]        htotal,
  output logic [9:0]        hactive,
  output logic [9:0]        vtotal,
  output logic [9:0]        vactive,
  output logic              hs_pol,
  output logic              vs_pol,
  output logic [15:0]       frame_sum,
  output logic [7:0]        lost_count
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage 1: registered copy of every input pin
  logic              hs_p1, vs_p1, hb_p1, vb_p1;
  logic [DATA_W-1:0] r_p1, g_p1, b_p1;
  // Stage 2: delayed hblank, only needed for the falling-edge (line start) test
  logic              hb_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
      hb_p1 <= 1'b0;
      vb_p1 <= 1'b0;
      r_p1  <= '0;
      g_p1  <= '0;
      b_p1  <= '0;
      hb_p2 <= 1'b0;
    end else begin
      hs_p1 <= hsync;
      vs_p1 <= vsync;
      hb_p1 <= hblank;
      vb_p1 <= vblank;
      r_p1  <= r;
      g_p1  <= g;
      b_p1  <= b;
      hb_p2 <= hb_p1;
    end
  end

  // Event decode on the stage-1/stage-2 pair
  logic        vb_seen;
  logic        line_start, frame_start, visible;
  logic [15:0] px_p1;

  assign line_start  = ~hb_p1 & hb_p2;
  assign frame_start = line_start & ~vb_p1 & vb_seen;
  assign visible     = ~hb_p1 & ~vb_p1;
  assign px_p1       = 16'(r_p1 ^ g_p1 ^ b_p1);

  // Running measurement counters (cycles/lines since the last boundary)
  logic [CNT_W-1:0] hcyc, hact, vcnt, vact;
  logic [CNT_W-1:0] ref_h, ref_v;
  logic [15:0]      acc;
  logic             h_ok;
  logic             sat_any;

  assign sat_any = (hcyc == CNT_MAX) | (hact == CNT_MAX) | (vcnt == CNT_MAX) |
                   (vact == CNT_MAX) | (hpos == CNT_MAX) | (vpos == CNT_MAX);

  state_t state, state_next;
  logic   load_ref, lose;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_ref   = 1'b0;
    lose       = 1'b0;
    case (state)
      SEARCH: begin
        if (frame_start) state_next = MEASURE;
      end
      MEASURE: begin
        if (frame_start) begin
          load_ref   = 1'b1;
          state_next = VERIFY;
        end
      end
      VERIFY: begin
        // The frame-start line itself closes the last line of the frame,
        // so its length is checked here alongside the accumulated flag.
        if (frame_start) begin
          if (h_ok && (hcyc == ref_h) && (vcnt == ref_v)) state_next = LOCKED;
          else                                            load_ref   = 1'b1;
        end
      end
      LOCKED: begin
        if (sat_any || (line_start && (hcyc != ref_h)) ||
            (frame_start && (vcnt != ref_v))) begin
          lose       = 1'b1;
          state_next = SEARCH;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

  // Output stage: measurements, coordinates and qualified pixel strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcyc       <= '0;
      hact       <= '0;
      vcnt       <= '0;
      vact       <= '0;
      ref_h      <= '0;
      ref_v      <= '0;
      acc        <= '0;
      h_ok       <= 1'b0;
      vb_seen    <= 1'b0;
      htotal     <= '0;
      hactive    <= '0;
      vtotal     <= '0;
      vactive    <= '0;
      hpos       <= '0;
      vpos       <= '0;
      hs_pol     <= 1'b0;
      vs_pol     <= 1'b0;
      frame_sum  <= '0;
      pix_valid  <= 1'b0;
      lost_count <= '0;
    end else begin
      if (line_start) begin
        htotal  <= hcyc;
        hactive <= hact;
        hcyc    <= CNT_W'(1);
        hact    <= CNT_W'(1);
        hpos    <= '0;
      end else begin
        hcyc <= sat_inc(hcyc);
        if (!hb_p1)  hact <= sat_inc(hact);
        if (visible) hpos <= sat_inc(hpos);
      end

      if (frame_start) begin
        vtotal    <= vcnt;
        vactive   <= vact;
        vcnt      <= CNT_W'(1);
        vact      <= CNT_W'(1);
        vpos      <= '0;
        vb_seen   <= 1'b0;
        frame_sum <= acc;
        // The frame-start pixel is visible and belongs to the new frame.
        acc       <= px_p1;
      end else begin
        if (line_start) vcnt <= sat_inc(vcnt);
        if (line_start && !vb_p1) begin
          vact <= sat_inc(vact);
          vpos <= sat_inc(vpos);
        end
        if (vb_p1)   vb_seen <= 1'b1;
        if (visible) acc     <= acc + px_p1;
      end

      // During active video the sync lines sit at their inactive level.
      if (visible) begin
        hs_pol <= ~hs_p1;
        vs_pol <= ~vs_p1;
      end

      if (load_ref) begin
        ref_h <= hcyc;
        ref_v <= vcnt;
        h_ok  <= 1'b1;
      end else if ((state == VERIFY) && line_start && (hcyc != ref_h)) begin
        h_ok <= 1'b0;
      end

      // Next-state qualification blanks the pixel on the exit cycle and
      // lets the first pixel of the locking frame through.
      pix_valid <= visible && (state_next == LOCKED);

      if (lose) lost_count <= sat_inc8(lost_count);
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_rx_monitor
//
// Drives a reduced VGA format (24 x 14 total, 16 x 10 active) through the
// monitor. Expected visible pixels (coordinates and arrival cycle) are queued
// as they are driven; a monitor process pops them whenever pix_valid is seen.
// Geometry, lock, polarity, checksum and reset behaviour are checked directly.
// ---------------------------------------------------------------------------
module tb_vga_rx_monitor;

  localparam int HT  = 24;
  localparam int HA  = 16;
  localparam int HS0 = 18;
  localparam int HS1 = 21;
  localparam int VT  = 14;
  localparam int VA  = 10;
  localparam int VS0 = 11;
  localparam int VS1 = 13;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync, vsync, hblank, vblank;
  logic [7:0] r, g, b;
  logic       pix_valid;
  logic [9:0] hpos, vpos;
  logic       locked;
  logic [9:0] htotal, hactive, vtotal, vactive;
  logic       hs_pol, vs_pol;
  logic [15:0] frame_sum;
  logic [7:0] lost_count;

  vga_rx_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblank     (hblank),
    .vblank     (vblank),
    .r          (r),
    .g          (g),
    .b          (b),
    .pix_valid  (pix_valid),
    .hpos       (hpos),
    .vpos       (vpos),
    .locked     (locked),
    .htotal     (htotal),
    .hactive    (hactive),
    .vtotal     (vtotal),
    .vactive    (vactive),
    .hs_pol     (hs_pol),
    .vs_pol     (vs_pol),
    .frame_sum  (frame_sum),
    .lost_count (lost_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cyc;
    int x;
    int y;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] sums [0:15];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pix_valid) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL pix_unexpected: got (%0d,%0d) at cycle %0d, required no pixel",
                   hpos, vpos, cyc);
        end else begin
          e = sb_q.pop_front();
          if (hpos !== 10'(e.x) || vpos !== 10'(e.y) || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL pix: got (%0d,%0d) at cycle %0d, required (%0d,%0d) at cycle %0d",
                     hpos, vpos, cyc, e.x, e.y, e.cyc);
          end
        end
      end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL pix_missing: got pix_valid=0 at cycle %0d, required (%0d,%0d)",
                 cyc, e.x, e.y);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive lines y0..y1 of frame f. Line long_y gets one extra blanking cycle.
  // Visible pixels on lines below valid_until are expected on pix_valid.
  task automatic send_lines(input int f, input int y0, input int y1,
                            input int long_y, input int valid_until,
                            input bit pos, input bit mode0);
    exp_t e;
    int   len;
    for (int y = y0; y <= y1; y++) begin
      len = (y == long_y) ? HT + 1 : HT;
      for (int x = 0; x < len; x++) begin
        tick();
        hblank = (x >= HA);
        vblank = (y >= VA);
        hsync  = (x >= HS0 && x < HS1) ? pos : ~pos;
        vsync  = (y >= VS0 && y < VS1) ? pos : ~pos;
        if (!hblank && !vblank) begin
          if (mode0) begin
            r = 8'h01; g = 8'h00; b = 8'h00;
          end else begin
            r = 8'(x * 7 + f); g = 8'(y * 13); b = 8'hA5;
          end
          sums[f] = sums[f] + 16'(r ^ g ^ b);
          if (y < valid_until) begin
            e.cyc = cyc + 2;
            e.x   = x;
            e.y   = y;
            sb_q.push_back(e);
          end
        end else begin
          r = 8'h00; g = 8'h00; b = 8'h00;
        end
      end
    end
  endtask

  task automatic check_geom(input string tag);
    check({tag, "_htotal"},  int'(htotal),  HT);
    check({tag, "_hactive"}, int'(hactive), HA);
    check({tag, "_vtotal"},  int'(vtotal),  VT);
    check({tag, "_vactive"}, int'(vactive), VA);
  endtask

  initial begin
    int vu;
    for (int i = 0; i < 16; i++) sums[i] = '0;
    rst_n  = 1'b0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    hblank = 1'b1;
    vblank = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;

    repeat (3) tick();
    check("rst_pix_valid",  int'(pix_valid),  0);
    check("rst_locked",     int'(locked),     0);
    check("rst_htotal",     int'(htotal),     0);
    check("rst_vtotal",     int'(vtotal),     0);
    check("rst_frame_sum",  int'(frame_sum),  0);
    check("rst_lost_count", int'(lost_count), 0);
    check("rst_hs_pol",     int'(hs_pol),     0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Frames 0..9: acquire, lose on a long line, reacquire
    for (int f = 0; f < 10; f++) begin
      if (f >= 3 && f != 7 && f != 8) vu = (f == 6) ? 5 : VT;
      else                            vu = 0;
      send_lines(f, 0, VT - 1, (f == 6) ? 4 : -1, vu, 1'b0, (f == 5));
      if (f >= 2)
        check($sformatf("frame_sum_f%0d", f), int'(frame_sum),
              (f == 6) ? 16'h00A0 : int'(sums[f - 1]));
      if (f == 2 || f == 8) check($sformatf("locked_f%0d", f), int'(locked), 0);
      if (f == 3 || f == 9) check($sformatf("locked_f%0d", f), int'(locked), 1);
      if (f == 3) begin
        check_geom("f3");
        check("f3_hs_pol", int'(hs_pol), 0);
        check("f3_vs_pol", int'(vs_pol), 0);
      end
      if (f == 6) begin
        check("f6_locked",     int'(locked),     0);
        check("f6_lost_count", int'(lost_count), 1);
      end
      if (f == 9) check("f9_lost_count", int'(lost_count), 1);
    end

    // Frame 10: hblank stuck high long enough to saturate the line counter
    send_lines(10, 0, 2, -1, 3, 1'b0, 1'b0);
    repeat (2000) begin
      tick();
      hblank = 1'b1;
      vblank = 1'b0;
      hsync  = 1'b1;
      r = 8'h00; g = 8'h00; b = 8'h00;
    end
    check("sat_locked",     int'(locked),     0);
    check("sat_lost_count", int'(lost_count), 2);
    send_lines(10, 3, 3, -1, 0, 1'b0, 1'b0);
    check("sat_htotal", int'(htotal), 1023);
    send_lines(10, 4, VT - 1, -1, 0, 1'b0, 1'b0);

    // Frame 11: asynchronous reset in the middle of the frame
    send_lines(11, 0, 4, -1, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lost_count", int'(lost_count), 0);
    check("arst_htotal",     int'(htotal),     0);
    check("arst_vtotal",     int'(vtotal),     0);
    check("arst_frame_sum",  int'(frame_sum),  0);
    check("arst_vpos",       int'(vpos),       0);
    check("arst_locked",     int'(locked),     0);
    check("arst_pix_valid",  int'(pix_valid),  0);
    repeat (3) tick();
    rst_n = 1'b1;
    send_lines(11, 5, VT - 1, -1, 0, 1'b0, 1'b0);

    // Frames 12..14: full relock with active-high syncs
    send_lines(12, 0, VT - 1, -1, 0, 1'b1, 1'b0);
    send_lines(13, 0, VT - 1, -1, 0, 1'b1, 1'b0);
    check("f13_locked", int'(locked), 0);
    send_lines(14, 0, VT - 1, -1, VT, 1'b1, 1'b0);
    check("f14_locked",     int'(locked),     1);
    check("f14_lost_count", int'(lost_count), 0);
    check("f14_hs_pol",     int'(hs_pol),     1);
    check("f14_vs_pol",     int'(vs_pol),     1);
    check_geom("f14");

    repeat (5) tick();
    check("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
